// File: rtl/stack_seq_ctrl_if.sv
// Command/response handshake bundle between a command source and stack_seq_ctrl.
interface stack_seq_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_err;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/stack_seq_ctrl.sv
// Stack-machine command sequencer: turns one command into push/pop strobes for an operand stack.
// Opcode 7 (DUP) is built only when STACK_SEQ_DUP_EN is defined; otherwise it is rejected.
module stack_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_seq_ctrl_if.slave       bus_if,
  output logic [$clog2(DEPTH):0] depth_count_o,
  output logic                  stk_push_o,
  output logic                  stk_pop_o,
  output logic [WIDTH-1:0]      stk_din_o,
  input  logic [WIDTH-1:0]      stk_dout_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP1  = 3'd1,
    S_POP2  = 3'd2,
    S_CAP   = 3'd3,
    S_EXEC  = 3'd4,
    S_PUSH  = 3'd5,
`ifdef STACK_SEQ_DUP_EN
    S_PUSH2 = 3'd6,
`endif
    S_DONE  = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic              err_q, err_d;
  logic [CW-1:0]     count_q, count_d;

  logic              accept;
  logic              legal;
  logic              cmd_ready_s;
  logic              rsp_valid_s;
  logic              rsp_err_s;
  logic [WIDTH-1:0]  rsp_data_s;

  assign accept = bus_if.cmd_valid & cmd_ready_s;

  // Occupancy rules checked against the committed count at the accept edge.
  always_comb begin
    legal = 1'b0;
    case (bus_if.cmd_op)
      OP_NOP:  legal = 1'b1;
      OP_PUSH: legal = (count_q < CNT_FULL);
      OP_POP:  legal = (count_q >= CNT_ONE);
      OP_ADD, OP_SUB, OP_AND, OP_XOR: legal = (count_q >= CNT_TWO);
      OP_DUP: begin
`ifdef STACK_SEQ_DUP_EN
        legal = (count_q >= CNT_ONE) && (count_q < CNT_FULL);
`else
        legal = 1'b0;
`endif
      end
      default: legal = 1'b0;
    endcase
  end

  // Next-state and datapath; a_q holds the immediate, popped operand or result in turn.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus_if.cmd_op;
          err_d = ~legal;
          a_d   = {WIDTH{1'b0}};
          if (!legal || (bus_if.cmd_op == OP_NOP)) begin
            state_d = S_DONE;
          end else begin
            case (bus_if.cmd_op)
              OP_PUSH: begin
                a_d     = bus_if.cmd_data;
                count_d = count_q + CNT_ONE;
                state_d = S_PUSH;
              end
              OP_DUP: begin
                count_d = count_q + CNT_ONE;
                state_d = S_POP1;
              end
              default: begin
                count_d = count_q - CNT_ONE;
                state_d = S_POP1;
              end
            endcase
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP1: begin
        if ((op_q == OP_POP) || (op_q == OP_DUP)) begin
          state_d = S_CAP;
        end else begin
          state_d = S_POP2;
        end
      end
      S_POP2: begin
        a_d     = stk_dout_i;
        state_d = S_EXEC;
      end
      S_CAP: begin
        a_d = stk_dout_i;
        if (op_q == OP_DUP) begin
          state_d = S_PUSH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_EXEC: begin
        // stk_dout_i now holds the entry below the top (B); a_q is the former top (A).
        case (op_q)
          OP_ADD:  a_d = stk_dout_i + a_q;
          OP_SUB:  a_d = stk_dout_i - a_q;
          OP_AND:  a_d = stk_dout_i & a_q;
          OP_XOR:  a_d = stk_dout_i ^ a_q;
          default: a_d = a_q;
        endcase
        state_d = S_PUSH;
      end
      S_PUSH: begin
`ifdef STACK_SEQ_DUP_EN
        if (op_q == OP_DUP) begin
          state_d = S_PUSH2;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
`ifdef STACK_SEQ_DUP_EN
      S_PUSH2: state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= {WIDTH{1'b0}};
      err_q   <= 1'b0;
      count_q <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    cmd_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = {WIDTH{1'b0}};
    stk_push_o  = 1'b0;
    stk_pop_o   = 1'b0;
    stk_din_o   = {WIDTH{1'b0}};
    case (state_q)
      S_IDLE: cmd_ready_s = 1'b1;
      S_POP1: stk_pop_o   = 1'b1;
      S_POP2: stk_pop_o   = 1'b1;
      S_PUSH: begin
        stk_push_o = 1'b1;
        stk_din_o  = a_q;
      end
`ifdef STACK_SEQ_DUP_EN
      S_PUSH2: begin
        stk_push_o = 1'b1;
        stk_din_o  = a_q;
      end
`endif
      S_DONE: begin
        rsp_valid_s = 1'b1;
        rsp_err_s   = err_q;
        if (err_q) begin
          rsp_data_s = {WIDTH{1'b0}};
        end else begin
          rsp_data_s = a_q;
        end
      end
      default: cmd_ready_s = 1'b0;
    endcase
  end

  assign bus_if.cmd_ready = cmd_ready_s;
  assign bus_if.rsp_valid = rsp_valid_s;
  assign bus_if.rsp_err   = rsp_err_s;
  assign bus_if.rsp_data  = rsp_data_s;
  assign depth_count_o    = count_q;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed bench for stack_seq_ctrl with a behavioural 8-deep stack model attached.
module tb_stack_seq_ctrl;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic       err;
    logic [7:0] rdata;
    logic [3:0] lat;
    logic [1:0] push;
    logic [1:0] pop;
    logic [3:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] depth_count;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;

  int tests = 0;
  int fails = 0;
  int overlap = 0;

  stack_seq_ctrl_if #(.WIDTH(8)) bus_if ();

  stack_seq_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_if        (bus_if),
    .depth_count_o (depth_count),
    .stk_push_o    (stk_push),
    .stk_pop_o     (stk_pop),
    .stk_din_o     (stk_din),
    .stk_dout_i    (stk_dout)
  );

  always #5 clk = ~clk;

  // Stack model: registered output, valid the cycle after a pop.
  logic [7:0] mem [8];
  logic [3:0] sp;
  always @(posedge clk) begin
    if (reset) begin
      sp       <= 4'd0;
      stk_dout <= 8'h00;
    end else if (stk_push) begin
      if (sp < 4'd8) begin
        mem[sp[2:0]] <= stk_din;
        sp           <= sp + 4'd1;
      end
    end else if (stk_pop) begin
      if (sp > 4'd0) begin
        stk_dout <= mem[3'(sp - 4'd1)];
        sp       <= sp - 4'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (stk_push && stk_pop) overlap++;
  end

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] data, input logic err,
                              input logic [7:0] rdata, input int lat, input int push,
                              input int pop, input int cnt);
    vec_t v;
    v.op = op; v.data = data; v.err = err; v.rdata = rdata;
    v.lat = 4'(lat); v.push = 2'(push); v.pop = 2'(pop); v.cnt = 4'(cnt);
    return v;
  endfunction

  task automatic do_cmd(input vec_t v, input string tag);
    int n;
    int pushes;
    int pops;
    int lat;
    bit got;
    logic       err;
    logic [7:0] rdata;
    n = 0;
    while (!bus_if.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, "ready", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = v.op;
    bus_if.cmd_data  = v.data;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 3'($urandom);
    bus_if.cmd_data  = 8'($urandom);
    got = 1'b0; lat = 0; pushes = 0; pops = 0; err = 1'b0; rdata = 8'h00;
    for (int c = 1; c <= 20 && !got; c++) begin
      pushes += int'(stk_push);
      pops   += int'(stk_pop);
      if (bus_if.rsp_valid) begin
        got   = 1'b1;
        lat   = c;
        err   = bus_if.rsp_err;
        rdata = bus_if.rsp_data;
      end else begin
        @(negedge clk);
      end
    end
    check(tag, "rsp_seen", 32'(got), 32'd1);
    check(tag, "latency", 32'(lat), 32'(v.lat));
    check(tag, "rsp_err", 32'(err), 32'(v.err));
    check(tag, "rsp_data", 32'(rdata), 32'(v.rdata));
    check(tag, "push_pulses", 32'(pushes), 32'(v.push));
    check(tag, "pop_pulses", 32'(pops), 32'(v.pop));
    check(tag, "depth_count", 32'(depth_count), 32'(v.cnt));
    @(negedge clk);
    check(tag, "rsp_one_cycle", 32'(bus_if.rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[$];
  int   rsp_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 3'd0;
    bus_if.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset", "cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("reset", "rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("reset", "rsp_err", 32'(bus_if.rsp_err), 32'd0);
    check("reset", "rsp_data", 32'(bus_if.rsp_data), 32'd0);
    check("reset", "depth_count", 32'(depth_count), 32'd0);
    check("reset", "stk_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
    check("reset", "stk_din", 32'(stk_din), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //            op       data   err rdata lat push pop cnt
    vecs.push_back(mk(OP_PUSH, 8'h05, 1'b0, 8'h05, 2, 1, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'h03, 1'b0, 8'h03, 2, 1, 0, 2));
    vecs.push_back(mk(OP_SUB,  8'hEE, 1'b0, 8'h02, 5, 1, 2, 1));
    vecs.push_back(mk(OP_POP,  8'h00, 1'b0, 8'h02, 3, 0, 1, 0));
    vecs.push_back(mk(OP_POP,  8'h00, 1'b1, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(OP_ADD,  8'h00, 1'b1, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(OP_NOP,  8'h99, 1'b0, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(OP_PUSH, 8'h77, 1'b0, 8'h77, 2, 1, 0, 1));
    vecs.push_back(mk(OP_ADD,  8'h00, 1'b1, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(OP_POP,  8'h00, 1'b0, 8'h77, 3, 0, 1, 0));
    vecs.push_back(mk(OP_PUSH, 8'hF0, 1'b0, 8'hF0, 2, 1, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'h20, 1'b0, 8'h20, 2, 1, 0, 2));
    vecs.push_back(mk(OP_ADD,  8'h00, 1'b0, 8'h10, 5, 1, 2, 1));
    vecs.push_back(mk(OP_PUSH, 8'h0F, 1'b0, 8'h0F, 2, 1, 0, 2));
    vecs.push_back(mk(OP_XOR,  8'h00, 1'b0, 8'h1F, 5, 1, 2, 1));
    vecs.push_back(mk(OP_PUSH, 8'h00, 1'b0, 8'h00, 2, 1, 0, 2));
    vecs.push_back(mk(OP_PUSH, 8'h01, 1'b0, 8'h01, 2, 1, 0, 3));
    vecs.push_back(mk(OP_SUB,  8'h00, 1'b0, 8'hFF, 5, 1, 2, 2));
    vecs.push_back(mk(OP_AND,  8'h00, 1'b0, 8'h1F, 5, 1, 2, 1));
    vecs.push_back(mk(OP_POP,  8'h00, 1'b0, 8'h1F, 3, 0, 1, 0));
    vecs.push_back(mk(OP_PUSH, 8'h42, 1'b0, 8'h42, 2, 1, 0, 1));
`ifdef STACK_SEQ_DUP_EN
    vecs.push_back(mk(OP_DUP,  8'h00, 1'b0, 8'h42, 5, 2, 1, 2));
    vecs.push_back(mk(OP_POP,  8'h00, 1'b0, 8'h42, 3, 0, 1, 1));
    vecs.push_back(mk(OP_POP,  8'h00, 1'b0, 8'h42, 3, 0, 1, 0));
`else
    vecs.push_back(mk(OP_DUP,  8'h00, 1'b1, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(OP_POP,  8'h00, 1'b0, 8'h42, 3, 0, 1, 0));
`endif

    foreach (vecs[i]) do_cmd(vecs[i], $sformatf("vec%0d", i));

    // Fill to capacity, then an overflowing push must be rejected without touching the stack.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_cmd(mk(OP_PUSH, 8'(8'h10 + i), 1'b0, 8'(8'h10 + i), 2, 1, 0, i + 1), $sformatf("fill%0d", i));
    end
    do_cmd(mk(OP_PUSH, 8'hAA, 1'b1, 8'h00, 1, 0, 0, 8), "overflow");
    do_cmd(mk(OP_POP,  8'h00, 1'b0, 8'h17, 3, 0, 1, 7), "pop_after_full");

    // Reset while an ADD sits in EXEC.
    do_reset();
    do_cmd(mk(OP_PUSH, 8'h01, 1'b0, 8'h01, 2, 1, 0, 1), "pre_add1");
    do_cmd(mk(OP_PUSH, 8'h02, 1'b0, 8'h02, 2, 1, 0, 2), "pre_add2");
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = OP_ADD;
    bus_if.cmd_data  = 8'h00;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    check("abort", "pop1_strobe", 32'(stk_pop), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("abort", "exec_no_strobe", {30'd0, stk_push, stk_pop}, 32'd0);
    check("abort", "exec_count", 32'(depth_count), 32'd1);
    check("abort", "exec_busy", 32'(bus_if.cmd_ready), 32'd0);
    reset = 1'b1;
    rsp_seen = 0;
    @(negedge clk);
    check("abort", "cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("abort", "depth_count", 32'(depth_count), 32'd0);
    check("abort", "rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("abort", "stk_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
    check("abort", "stk_din", 32'(stk_din), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rsp_seen += int'(bus_if.rsp_valid);
      @(negedge clk);
    end
    check("abort", "late_rsp", 32'(rsp_seen), 32'd0);
    do_cmd(mk(OP_PUSH, 8'h33, 1'b0, 8'h33, 2, 1, 0, 1), "post_abort");
    do_cmd(mk(OP_POP,  8'h00, 1'b0, 8'h33, 3, 0, 1, 0), "post_abort_pop");

    check("global", "push_pop_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
